// File: rtl/wave_capture_pkg.sv
// rtl/wave_capture_pkg.sv - shared capture/display constants and sample conversion
package wave_capture_pkg;

  localparam logic [1:0] ST_ARMED  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  localparam int ADDR_W = 9;
  localparam int DISP_W = 8;

  // Flipping the sign bit turns a two's-complement byte into offset binary.
  localparam logic [DISP_W-1:0] OB_FLIP = 8'h80;

  function automatic logic [DISP_W-1:0] to_offset_binary(input logic [DISP_W-1:0] msbyte);
    return msbyte ^ OB_FLIP;
  endfunction

endpackage

// File: rtl/wave_capture_zero_cross.sv
// rtl/wave_capture_zero_cross.sv - zero_cross_detect: flags a negative-to-non-negative sample step
module zero_cross_detect (
  input  logic clk,
  input  logic reset,
  input  logic sample_valid,
  input  logic sample_msb,
  output logic crossing
);

  logic prev_neg_q;
  logic prev_neg_d;

  always_comb begin
    prev_neg_d = prev_neg_q;
    if (sample_valid) begin
      prev_neg_d = sample_msb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_neg_q <= 1'b0;
    end else begin
      prev_neg_q <= prev_neg_d;
    end
  end

  assign crossing = sample_valid & prev_neg_q & ~sample_msb;

endmodule

// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - triggered ping-pong frame capture of codec samples for the scope display
// Optional macro WAVE_CAPTURE_AUTO_TRIGGER_EN forces a capture after AUTO_TIMEOUT untriggered samples.
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int N_SAMPLES    = 256,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [ADDR_W-1:0]   write_address,
  output logic                write_enable,
  output logic [DISP_W-1:0]   write_sample,
  output logic                read_index
);

  localparam int OFF_W = $clog2(N_SAMPLES);

  logic [1:0]        state_q, state_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic              read_index_q, read_index_d;
  logic              write_enable_q, write_enable_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic [DISP_W-1:0] write_sample_q, write_sample_d;

  logic crossing;
  logic trigger;
  logic write_now;
  logic last_slot;
  logic unused_sample_lsbs;

  assign unused_sample_lsbs = ^new_sample_in[SAMPLE_W-DISP_W-1:0];

  zero_cross_detect u_zero_cross (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (new_sample_ready),
    .sample_msb   (new_sample_in[SAMPLE_W-1]),
    .crossing     (crossing)
  );

`ifdef WAVE_CAPTURE_AUTO_TRIGGER_EN
  localparam int CNT_W = $clog2(AUTO_TIMEOUT + 1);

  logic [CNT_W-1:0] quiet_cnt_q, quiet_cnt_d;
  logic             timed_out;

  assign timed_out = (quiet_cnt_q >= CNT_W'(AUTO_TIMEOUT));
  assign trigger   = crossing | (new_sample_ready & timed_out);

  // Held at zero outside ARMED, so every entry into ARMED starts a fresh count.
  always_comb begin
    quiet_cnt_d = quiet_cnt_q;
    if (state_q != ST_ARMED || trigger) begin
      quiet_cnt_d = '0;
    end else if (new_sample_ready) begin
      quiet_cnt_d = quiet_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quiet_cnt_q <= '0;
    end else begin
      quiet_cnt_q <= quiet_cnt_d;
    end
  end
`else
  localparam int unused_auto_timeout = AUTO_TIMEOUT;

  assign trigger = crossing;
`endif

  assign last_slot = (offset_q == OFF_W'(N_SAMPLES - 1));
  assign write_now = ((state_q == ST_ARMED) && trigger) ||
                     ((state_q == ST_ACTIVE) && new_sample_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARMED:  if (trigger) state_d = ST_ACTIVE;
      ST_ACTIVE: if (new_sample_ready && last_slot) state_d = ST_WAIT;
      ST_WAIT:   if (wave_display_idle) state_d = ST_ARMED;
      default:   state_d = ST_ARMED;
    endcase
  end

  // Offset is always 0 in ARMED, so one write path serves the trigger sample too.
  always_comb begin
    offset_d        = offset_q;
    read_index_d    = read_index_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_sample_d  = write_sample_q;
    if (write_now) begin
      write_enable_d  = 1'b1;
      write_address_d = {~read_index_q, (ADDR_W-1)'(offset_q)};
      write_sample_d  = to_offset_binary(new_sample_in[SAMPLE_W-1 -: DISP_W]);
      offset_d        = last_slot ? '0 : offset_q + OFF_W'(1);
    end
    if (state_q == ST_WAIT && wave_display_idle) begin
      read_index_d = ~read_index_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset_q        <= '0;
      read_index_q    <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_sample_q  <= '0;
    end else begin
      offset_q        <= offset_d;
      read_index_q    <= read_index_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_sample_q  <= write_sample_d;
    end
  end

  assign write_enable  = write_enable_q;
  assign write_address = write_address_q;
  assign write_sample  = write_sample_q;
  assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// tb/tb_wave_capture.sv - self-checking bench for wave_capture
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = 16'h0000;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] smp;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    string       name;
    logic [15:0] s0;
    logic [15:0] s1;
    bit          trig;
    logic [7:0]  exp_smp;
  } vec_t;
  vec_t tbl[6];

  wave_capture dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ob(input logic [15:0] s);
    return {~s[15], s[14:8]};
  endfunction

  task automatic put(input logic [15:0] s);
    @(negedge clk);
    new_sample_ready = 1'b1;
    new_sample_in    = s;
    @(negedge clk);
    new_sample_ready = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && write_enable) begin
      wr_t e;
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {23'd0, write_address}, 32'h1ff);
        n_fail++;
        $display("FAIL unexpected_write: addr %0h sample %0h, none expected", write_address, write_sample);
      end else begin
        e = exp_q.pop_front();
        check("write_address", {23'd0, write_address}, {23'd0, e.addr});
        check("write_sample", {24'd0, write_sample}, {24'd0, e.smp});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_snap;
    int toggles;
    logic ri_prev;
    logic [15:0] s;

    tbl[0] = '{"cross_basic",  16'h8000, 16'h0100, 1'b1, 8'h81};
    tbl[1] = '{"cross_zero",   16'h8000, 16'h0000, 1'b1, 8'h80};
    tbl[2] = '{"cross_max",    16'hFFFF, 16'h7FFF, 1'b1, 8'hFF};
    tbl[3] = '{"pos_pos",      16'h0100, 16'h0200, 1'b0, 8'h00};
    tbl[4] = '{"neg_neg",      16'h8000, 16'h8001, 1'b0, 8'h00};
    tbl[5] = '{"pos_to_neg",   16'h0000, 16'h8000, 1'b0, 8'h00};

    #1;
    check("rst_we", {31'd0, write_enable}, 0);
    check("rst_addr", {23'd0, write_address}, 0);
    check("rst_sample", {24'd0, write_sample}, 0);
    check("rst_ri", {31'd0, read_index}, 0);
    idle_cycles(2);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      pulse_reset();
      wr_snap = n_writes;
      put(tbl[i].s0);
      if (tbl[i].trig) exp_q.push_back('{9'h100, tbl[i].exp_smp});
      put(tbl[i].s1);
      idle_cycles(3);
      check({tbl[i].name, "_nwrites"}, n_writes - wr_snap, {31'd0, tbl[i].trig});
      check({tbl[i].name, "_ri"}, {31'd0, read_index}, 0);
    end

    pulse_reset();
    put(16'h8000);
    exp_q.push_back('{9'h100, 8'h81});
    put(16'h0100);
    check("frame1_ri", {31'd0, read_index}, 0);
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      new_sample_ready = 1'b1;
      s = {i[7:0], 8'h00};
      new_sample_in = s;
      exp_q.push_back('{9'h100 + 9'(i), ob(s)});
    end
    @(negedge clk);
    new_sample_ready = 1'b0;
    idle_cycles(2);
    check("frame1_drained", exp_q.size(), 0);
    wr_snap = n_writes;
    put(16'h8000);
    put(16'h0100);
    idle_cycles(3);
    check("wait_no_write", n_writes - wr_snap, 0);
    check("wait_we_low", {31'd0, write_enable}, 0);
    check("wait_ri", {31'd0, read_index}, 0);

    toggles = 0;
    ri_prev = read_index;
    wave_display_idle = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (read_index !== ri_prev) toggles++;
      ri_prev = read_index;
    end
    wave_display_idle = 1'b0;
    check("swap_toggles", toggles, 1);
    check("swap_ri", {31'd0, read_index}, 1);

    put(16'h8000);
    exp_q.push_back('{9'h000, 8'h81});
    put(16'h0100);
    for (int i = 1; i < 99; i++) begin
      @(negedge clk);
      new_sample_ready = 1'b1;
      s = 16'($urandom);
      new_sample_in = s;
      exp_q.push_back('{9'(i), ob(s)});
    end
    @(negedge clk);
    new_sample_in = 16'h1234;
    @(posedge clk);
    #1;
    check("mid_we_before_rst", {31'd0, write_enable}, 1);
    check("mid_addr_before_rst", {23'd0, write_address}, 9'h063);
    reset = 1'b1;
    new_sample_ready = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, write_enable}, 0);
    check("mid_rst_addr", {23'd0, write_address}, 0);
    check("mid_rst_sample", {24'd0, write_sample}, 0);
    check("mid_rst_ri", {31'd0, read_index}, 0);
    check("mid_rst_drained", exp_q.size(), 0);
    @(negedge clk);
    reset = 1'b0;

    put(16'h8000);
    exp_q.push_back('{9'h100, 8'h81});
    put(16'h0100);
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      new_sample_ready = 1'b1;
      s = 16'($urandom);
      new_sample_in = s;
      exp_q.push_back('{9'h100 + 9'(i), ob(s)});
    end
    @(negedge clk);
    new_sample_ready = 1'b0;
    idle_cycles(2);
    check("frame2_drained", exp_q.size(), 0);
    check("frame2_ri", {31'd0, read_index}, 0);

`ifndef WAVE_CAPTURE_AUTO_TRIGGER_EN
    put(16'h0100);
    wave_display_idle = 1'b1;
    @(negedge clk);
    wave_display_idle = 1'b0;
    check("notrig_ri", {31'd0, read_index}, 1);
    wr_snap = n_writes;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      new_sample_ready = 1'b1;
      new_sample_in = 16'h0040;
    end
    @(negedge clk);
    new_sample_ready = 1'b0;
    idle_cycles(3);
    check("notrig_writes", n_writes - wr_snap, 0);
    check("notrig_ri_hold", {31'd0, read_index}, 1);
`endif

    check("final_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
